// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte-stream input, instruction-memory write port and load status of the loader
interface instr_mem_loader_if #(parameter int ADDR_W = 7);
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   word_count;
  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, overflow, word_count
  );
  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, overflow, word_count
  );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs a byte stream MSB-first into 32-bit words and writes them to instruction memory until END
module instr_mem_loader #(
  parameter int          DEPTH    = 128,
  parameter int          ADDR_W   = 7,
  parameter logic [31:0] END_WORD = 32'hFFFF_FFFF
) (
  input logic               clk,
  input logic               rst,
  instr_mem_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, ERR} state_t;
  state_t            state_q, state_d;
  logic [23:0]       shift_q, shift_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              byte_ready_q, byte_ready_d;
  logic              mem_we_q, mem_we_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic              can_start, fire, is_end, is_last;
  assign can_start = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);
  assign fire      = (state_q == COLLECT) && bus.byte_valid && byte_ready_q;
  assign is_end    = mem_wdata_q == END_WORD;
  assign is_last   = mem_addr_q == ADDR_W'(DEPTH - 1);
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    word_count_d = word_count_q;
    if (can_start && bus.start) begin
      state_d      = COLLECT;
      shift_d      = '0;
      idx_d        = '0;
      mem_addr_d   = '0;
      word_count_d = '0;
    end else if (fire) begin
      shift_d     = {shift_q[15:0], bus.byte_in};
      idx_d       = idx_q + 2'd1;
      mem_wdata_d = (idx_q == 2'd3) ? {shift_q, bus.byte_in} : mem_wdata_q;
      state_d     = (idx_q == 2'd3) ? WRITE : COLLECT;
    end else if (state_q == WRITE) begin
      word_count_d = word_count_q + 1'b1;
      state_d      = is_end ? DONE : is_last ? ERR : COLLECT;
      mem_addr_d   = (is_end || is_last) ? mem_addr_q : mem_addr_q + 1'b1;
    end
    // outputs are registered from the next state so they line up with it
    byte_ready_d = state_d == COLLECT;
    mem_we_d     = state_d == WRITE;
    cpu_hold_d   = (state_d == COLLECT) || (state_d == WRITE);
    done_d       = state_d == DONE;
    overflow_d   = state_d == ERR;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      word_count_q <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      word_count_q <= word_count_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end
  assign bus.byte_ready = byte_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.done       = done_q;
  assign bus.overflow   = overflow_q;
  assign bus.word_count = word_count_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: randomized scoreboard bench; a word-level model predicts every memory write and the final status
module tb_instr_mem_loader;
  localparam int DEPTH = 128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  instr_mem_loader_if #(.ADDR_W(7)) bus ();
  instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(7), .END_WORD(32'hFFFF_FFFF)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {logic [6:0] a; logic [31:0] d;} wr_t;
  wr_t        exp_q[$];
  logic [7:0] prog[$];
  int         tests = 0;
  int         fails = 0;
  logic       prev_we = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: every memory write must match the head of the expected-write queue
  always @(negedge clk) begin
    if (!rst && bus.mem_we) begin
      wr_t e;
      chk("we_not_back_to_back", {31'd0, prev_we}, 32'd0);
      chk("ready_low_in_write", {31'd0, bus.byte_ready}, 32'd0);
      chk("hold_high_in_write", {31'd0, bus.cpu_hold}, 32'd1);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h, no write expected", bus.mem_addr, bus.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", {25'd0, bus.mem_addr}, {25'd0, e.a});
        chk("write_data", bus.mem_wdata, e.d);
      end
    end
    prev_we = rst ? 1'b0 : bus.mem_we;
  end
  task automatic push_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) prog.push_back(w[8*k +: 8]);
  endtask
  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom;
    return (w == 32'hFFFF_FFFF) ? 32'h0 : w;
  endfunction
  // offer one byte until it is taken; gap selects random byte_valid (1) or held high (0)
  task automatic send(input logic [7:0] b, input int gap);
    bit took = 0;
    int budget = 0;
    while (!took) begin
      @(negedge clk);
      bus.byte_in    = b;
      bus.byte_valid = gap ? 1'($urandom % 2) : 1'b1;
      took           = bus.byte_valid && bus.byte_ready;
      if (++budget > 1000) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: byte 0x%02h never accepted", b);
        took = 1;
      end
    end
  endtask
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  // model: pack prog into words; stop at END or when memory is full
  task automatic run_load(input string name, input int gap, input int mid_gap_at);
    int          n = 0;
    bit          ended = 0;
    logic [31:0] w;
    int          budget = 0;
    for (int i = 0; i + 3 < prog.size() && n < DEPTH && !ended; i += 4) begin
      w = {prog[i], prog[i+1], prog[i+2], prog[i+3]};
      exp_q.push_back('{a: 7'(n), d: w});
      n++;
      ended = (w == 32'hFFFF_FFFF);
    end
    pulse_start();
    chk({name, "_hold_after_start"}, {31'd0, bus.cpu_hold}, 32'd1);
    chk({name, "_count_cleared"}, {24'd0, bus.word_count}, 32'd0);
    for (int i = 0; i < 4 * n; i++) begin
      if (i == mid_gap_at) begin
        repeat (20) begin
          @(negedge clk);
          bus.byte_valid = 1'b0;
        end
      end
      send(prog[i], gap);
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    while (!(bus.done || bus.overflow) && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk({name, "_done"}, {31'd0, bus.done}, {31'd0, ended});
    chk({name, "_overflow"}, {31'd0, bus.overflow}, {31'd0, !ended});
    chk({name, "_word_count"}, {24'd0, bus.word_count}, 32'(n));
    chk({name, "_final_addr"}, {25'd0, bus.mem_addr}, 32'(n - 1));
    chk({name, "_hold_released"}, {31'd0, bus.cpu_hold}, 32'd0);
    chk({name, "_ready_low"}, {31'd0, bus.byte_ready}, 32'd0);
    chk({name, "_all_writes_seen"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask
  initial begin
    bus.start      = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    #12;
    chk("reset_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("reset_hold", {31'd0, bus.cpu_hold}, 32'd0);
    chk("reset_we", {31'd0, bus.mem_we}, 32'd0);
    chk("reset_count", {24'd0, bus.word_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prog = '{8'h10, 8'h42, 8'h00, 8'h01, 8'hF8, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_load("basic", 0, -1);
    run_load("gaps", 1, 6);
    prog.delete();
    repeat (DEPTH) push_word(32'h1122_3344);
    run_load("overflow", 0, -1);
    repeat (5) begin
      @(negedge clk);
      bus.byte_valid = 1'b1;
      chk("err_refuses_bytes", {31'd0, bus.byte_ready}, 32'd0);
    end
    bus.byte_valid = 1'b0;
    prog.delete();
    repeat (DEPTH - 1) push_word(rand_word());
    push_word(32'hFFFF_FFFF);
    run_load("end_at_last", 1, -1);
    prog.delete();
    push_word(32'hFFFF_FFFE);
    push_word(32'hFFFF_FFFF);
    run_load("near_end", 0, -1);
    for (int t = 0; t < 4; t++) begin
      prog.delete();
      repeat ($urandom_range(1, 10)) push_word(rand_word());
      push_word(32'hFFFF_FFFF);
      run_load("random", t % 2, int'($urandom_range(0, 3)));
    end
    pulse_start();
    send(8'hAA, 0);
    send(8'hBB, 0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    chk("pre_reset_hold", {31'd0, bus.cpu_hold}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hold", {31'd0, bus.cpu_hold}, 32'd0);
    chk("async_rst_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("async_rst_wdata", bus.mem_wdata, 32'd0);
    chk("async_rst_addr", {25'd0, bus.mem_addr}, 32'd0);
    chk("async_rst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prog = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_load("after_reset", 0, -1);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
